mem_4kb_slave: RTL and testbench
================================

# mem_4kb_slave

Slave side of the memory bus: a 4 KB, 32-bit-word memory that accepts requests on the valid/wr_rd/addr/wdata handshake and answers with ready/error/rdata. It sits directly downstream of the bus master and its driver clocking block, and is the DUT the memory testbench drives and monitors. It is a single-outstanding-transaction responder with programmable wait states and address checking.

## Interface
- ADDR_W, 15, byte-address width
- DATA_W, 32, data width (fixed at 32; word = 4 bytes)
- MEM_BYTES, 4096, addressable bytes; valid addresses 0..MEM_BYTES-1
- WAIT_STATES, 1, extra cycles between request capture and response (0..15)

- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  request present; held by master until ready
- wr_rd  in  1  1 = write, 0 = read; stable while valid
- addr  in  ADDR_W  byte address; stable while valid
- wdata  in  DATA_W  write data; stable while valid
- ready  out  1  one-cycle response strobe, completes the transfer
- error  out  1  qualified by ready; 1 = request rejected
- rdata  out  DATA_W  qualified by ready on reads

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: on posedge with valid=1, capture addr/wr_rd/wdata, load wait counter with WAIT_STATES; next state WAIT if WAIT_STATES>0, else RESP.
- WAIT: counter decrements each cycle; at count 1 -> RESP. Input changes ignored (captured copy used).
- RESP: ready=1 for exactly one cycle; next state IDLE unconditionally. valid is not sampled in RESP.
- Error check on captured address: error=1 if addr >= MEM_BYTES or addr[1:0] != 0.
- Write, no error: word addr[11:2] written with wdata on the edge entering RESP. Write with error: memory unchanged.
- Read, no error: rdata = word addr[11:2] during RESP. Read with error: rdata = 0.
- Outside RESP: ready=0, error=0, rdata=0.
- Memory contents are not reset; reads of never-written words return X in simulation.

## Timing
- Reset (async assert): state IDLE, counter 0, ready=0, error=0, rdata=0, immediately and held until the first posedge after deassertion.
- Reset mid-transaction: transaction abandoned, no response; a write not yet committed (still in WAIT) is lost.
- Latency: valid sampled at edge N -> ready high from edge N+1+WAIT_STATES for one cycle.
- All outputs registered; no combinational path from inputs to outputs.
- Master must drop valid, or present a new request, after sampling ready; a valid still high at the first IDLE edge after RESP starts a new transaction.
- Back-to-back throughput: one transfer per WAIT_STATES+2 cycles.

## Structure
- Package mem_pkg: state enum (IDLE, WAIT, RESP), MEM_BYTES, WORDS = MEM_BYTES/4, word-index width (10), ERR_RDATA = 32'h0.
- Sub-module mem_array: 1024x32 single-port synchronous RAM, with write enable, write data and word address. The read word for the captured address is valid by the RESP cycle.
- Top holds the FSM, wait counter, capture registers and address checker.

## Test plan
- Reset: assert rst_n=0 mid-WAIT -> ready/error/rdata=0 at once; the later read of the target word shows the old value, not the write.
- Write 0xA5A5_1234 to 0x0010 then read 0x0010 (WAIT_STATES=1) -> ready at N+2 each, error=0, rdata=0xA5A5_1234.
- Out of range: write 0xFFFF_FFFF to 0x1000, then read 0x1000 -> both ready with error=1, rdata=0; word 0x0000 unchanged.
- Misaligned: read 0x0006 -> ready with error=1, rdata=0.
- Boundary: write/read 0x0FFC and 0x0000 with distinct data -> both return their own data, error=0.
- WAIT_STATES=0 and 3, with valid held high continuously -> ready pulses every 2 and 5 cycles respectively, each exactly one cycle wide.

Source files
------------

// File: rtl/mem_4kb_slave_pkg.sv
// Shared types and constants for the 4 KB memory-bus slave.
package mem_pkg;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int unsigned WIDX_W    = 10;
  localparam int unsigned CNT_W     = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // A request is rejected when it falls past the array or is not word aligned.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return (32'(a) >= MEM_BYTES) || (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_4kb_slave_if.sv
// Valid/ready memory bus between master and the 4 KB slave.
interface mem_4kb_slave_if;
  import mem_pkg::*;

  logic              valid;
  logic              wr_rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              error;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, wr_rd, addr, wdata, input ready, error, rdata);
  modport slave  (input valid, wr_rd, addr, wdata, output ready, error, rdata);
endinterface

// File: rtl/mem_4kb_slave_mem_array.sv
// 1024x32 single-port synchronous RAM; the read register returns zero unless a read is enabled.
module mem_array
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [WIDX_W-1:0] i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= ERR_RDATA;
    else if (i_re) r_rdata <= r_mem[i_widx];
    else           r_rdata <= ERR_RDATA;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_4kb_slave.sv
// Single-outstanding memory-bus slave: request capture, wait states, address check, response strobe.
module mem_4kb_slave
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input logic            clk,
  input logic            rst_n,
  mem_4kb_slave_if.slave bus
);

  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  req_t              r_req, w_req_next;
  logic              r_ready, r_error;
  logic              w_enter_resp;
  logic              w_err;
  logic              w_we, w_re;
  logic [DATA_W-1:0] w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_req   <= w_req_next;
      r_ready <= w_enter_resp;
      r_error <= w_enter_resp & w_err;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_next   = r_cnt;
    w_req_next   = r_req;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.valid) begin
          w_req_next = '{wr_rd: bus.wr_rd, addr: bus.addr, wdata: bus.wdata};
          w_cnt_next = WS;
          if (WS != '0) begin
            w_next = WAIT;
          end else begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Commit and read use the request that will be held in RESP, so zero wait states work too.
  assign w_err = addr_err(w_req_next.addr);
  assign w_we  = w_enter_resp &  w_req_next.wr_rd & ~w_err;
  assign w_re  = w_enter_resp & ~w_req_next.wr_rd & ~w_err;

  mem_array u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_widx  (w_req_next.addr[WIDX_W+1:2]),
    .i_wdata (w_req_next.wdata),
    .o_rdata (w_rdata)
  );

  assign bus.ready = r_ready;
  assign bus.error = r_error;
  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_mem_4kb_slave.sv
// Directed bench for mem_4kb_slave at 0, 1 and 3 wait states.
module tb_mem_4kb_slave;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_4kb_slave_if bus1 ();
  mem_4kb_slave_if bus0 ();
  mem_4kb_slave_if bus3 ();

  mem_4kb_slave #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_4kb_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_4kb_slave #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Launch a request just after edge N; lat counts edges until ready is seen.
  task automatic xfer1(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output int lat, output logic err, output logic [DATA_W-1:0] rd,
                       output logic wide);
    lat = -1; err = 1'b0; rd = '0; wide = 1'b0;
    @(posedge clk); #1;
    bus1.valid = 1'b1; bus1.wr_rd = wr; bus1.addr = a; bus1.wdata = d;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus1.ready === 1'b1) begin
        lat = k; err = bus1.error; rd = bus1.rdata;
        break;
      end
    end
    bus1.valid = 1'b0;
    @(posedge clk); #1;
    wide = bus1.ready;
  endtask

  task automatic test_reset();
    bus1.valid = 0; bus0.valid = 0; bus3.valid = 0;
    bus1.wr_rd = 0; bus0.wr_rd = 0; bus3.wr_rd = 0;
    bus1.addr = '0; bus0.addr = '0; bus3.addr = '0;
    bus1.wdata = '0; bus0.wdata = '0; bus3.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus1.ready, bus1.error, bus0.ready, bus0.error, bus3.ready, bus3.error} !== 6'b0 ||
        bus1.rdata !== 32'h0 || bus0.rdata !== 32'h0 || bus3.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready/error=%b rdata1=%h want all zero",
               {bus1.ready, bus1.error, bus0.ready, bus0.error, bus3.ready, bus3.error}, bus1.rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus1.ready !== 1'b0 || bus1.rdata !== 32'h0) begin
      failures++;
      $display("FAIL after_reset: ready=%b rdata=%h want 0/0", bus1.ready, bus1.rdata);
    end
  endtask

  task automatic test_write_read();
    int lat; logic err; logic [31:0] rd; logic wide;
    xfer1(1'b1, 15'h0010, 32'hA5A5_1234, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b0 || wide !== 1'b0) begin
      failures++;
      $display("FAIL wr_0010: lat=%0d err=%b wide=%b want lat=2 err=0 wide=0", lat, err, wide);
    end
    xfer1(1'b0, 15'h0010, 32'h0, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'hA5A5_1234 || wide !== 1'b0) begin
      failures++;
      $display("FAIL rd_0010: lat=%0d err=%b rdata=%h wide=%b want 2/0/a5a51234/0", lat, err, rd, wide);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic err; logic [31:0] rd; logic wide;
    xfer1(1'b1, 15'h0000, 32'h0BAD_F00D, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b0) begin
      failures++;
      $display("FAIL wr_0000: lat=%0d err=%b want 2/0", lat, err);
    end
    xfer1(1'b1, 15'h1000, 32'hFFFF_FFFF, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL wr_1000: lat=%0d err=%b rdata=%h want 2/1/0", lat, err, rd);
    end
    xfer1(1'b0, 15'h1000, 32'h0, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL rd_1000: lat=%0d err=%b rdata=%h want 2/1/0", lat, err, rd);
    end
    xfer1(1'b0, 15'h0000, 32'h0, lat, err, rd, wide);
    checks++;
    if (err !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL word0_kept: err=%b rdata=%h want 0/0badf00d", err, rd);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic err; logic [31:0] rd; logic wide;
    xfer1(1'b0, 15'h0006, 32'h0, lat, err, rd, wide);
    checks++;
    if (lat !== 2 || err !== 1'b1 || rd !== 32'h0) begin
      failures++;
      $display("FAIL rd_0006: lat=%0d err=%b rdata=%h want 2/1/0", lat, err, rd);
    end
    xfer1(1'b1, 15'h0012, 32'h7777_7777, lat, err, rd, wide);
    xfer1(1'b0, 15'h0010, 32'h0, lat, err, rd, wide);
    checks++;
    if (err !== 1'b0 || rd !== 32'hA5A5_1234) begin
      failures++;
      $display("FAIL misaligned_wr_dropped: err=%b rdata=%h want 0/a5a51234", err, rd);
    end
  endtask

  task automatic test_boundary();
    int lat; logic err; logic [31:0] rd; logic wide;
    xfer1(1'b1, 15'h0FFC, 32'hCAFE_0FFC, lat, err, rd, wide);
    xfer1(1'b1, 15'h0000, 32'h1357_9BDF, lat, err, rd, wide);
    xfer1(1'b0, 15'h0FFC, 32'h0, lat, err, rd, wide);
    checks++;
    if (err !== 1'b0 || rd !== 32'hCAFE_0FFC) begin
      failures++;
      $display("FAIL rd_0ffc: err=%b rdata=%h want 0/cafe0ffc", err, rd);
    end
    xfer1(1'b0, 15'h0000, 32'h0, lat, err, rd, wide);
    checks++;
    if (err !== 1'b0 || rd !== 32'h1357_9BDF) begin
      failures++;
      $display("FAIL rd_0000: err=%b rdata=%h want 0/13579bdf", err, rd);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [31:0] rd; logic wide; logic seen;
    xfer1(1'b1, 15'h0020, 32'h1111_1111, lat, err, rd, wide);
    @(posedge clk); #1;
    bus1.valid = 1'b1; bus1.wr_rd = 1'b1; bus1.addr = 15'h0020; bus1.wdata = 32'h2222_2222;
    @(posedge clk); #1;
    rst_n = 1'b0; bus1.valid = 1'b0;
    #1;
    checks++;
    if (bus1.ready !== 1'b0 || bus1.error !== 1'b0 || bus1.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_wait: ready=%b error=%b rdata=%h want 0/0/0", bus1.ready, bus1.error, bus1.rdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    bus1.valid = 1'b1; bus1.wr_rd = 1'b0; bus1.addr = 15'h0020;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus1.ready === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1 || bus1.rdata !== 32'h1111_1111 || bus1.error !== 1'b0) begin
      failures++;
      $display("FAIL lost_write: seen=%b rdata=%h want 1/11111111", seen, bus1.rdata);
    end
    rst_n = 1'b0; bus1.valid = 1'b0;
    #1;
    checks++;
    if (bus1.ready !== 1'b0 || bus1.rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_in_resp: ready=%b rdata=%h want 0/0", bus1.ready, bus1.rdata);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [24:1] act0, act3, exp0, exp3;
    logic        err_seen;
    err_seen = 1'b0;
    @(posedge clk); #1;
    bus0.valid = 1'b1; bus0.wr_rd = 1'b1; bus0.addr = 15'h0008; bus0.wdata = 32'h0000_00A5;
    bus3.valid = 1'b1; bus3.wr_rd = 1'b1; bus3.addr = 15'h0008; bus3.wdata = 32'h0000_00A3;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      act0[c] = bus0.ready;
      act3[c] = bus3.ready;
      exp0[c] = (c % 2) == 1;
      exp3[c] = (c >= 4) && (((c - 4) % 5) == 0);
      if ((bus0.ready === 1'b1 && bus0.error !== 1'b0) || (bus3.ready === 1'b1 && bus3.error !== 1'b0))
        err_seen = 1'b1;
    end
    bus0.valid = 1'b0; bus3.valid = 1'b0;
    checks++;
    if (act0 !== exp0) begin
      failures++;
      $display("FAIL held_ws0: ready pattern=%b want %b", act0, exp0);
    end
    checks++;
    if (act3 !== exp3) begin
      failures++;
      $display("FAIL held_ws3: ready pattern=%b want %b", act3, exp3);
    end
    checks++;
    if (err_seen !== 1'b0) begin
      failures++;
      $display("FAIL held_error: error seen=%b want 0", err_seen);
    end
    repeat (8) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_misaligned();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
